// File: rtl/slm_pkg.sv
// Shared definitions for the SLM message path: arbiter state encoding,
// ASCII constants used by the message generators, and a pointer-wrap helper.
package slm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_L     = 8'h4C;
    localparam logic [7:0] ASCII_M     = 8'h4D;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_HASH  = 8'h23;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Increment with explicit wrap so NREQ need not be a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first active request at or after the
// pointer, wrapping at NREQ-1 back to 0.
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_onehot,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        logic w_found;
        int   w_j;
        // NOTE: every output gets a default before the loop so no path can infer a latch.
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NREQ) w_j = w_j - NREQ;
            if (!w_found && i_req[w_j]) begin
                w_found       = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_idx         = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single UART transmitter: grants whole messages,
// inserts an idle gap between messages and aborts on a missing tx_done.
module uart_tx_arbiter
    import slm_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int GAP_CYC = 2,
    parameter int TMO_CYC = 4095
) (
    input  logic              clk_3125,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   grant,
    output logic              tx_start,
    output logic [7:0]        tx_msg,
    input  logic              tx_done,
    output logic              busy,
    output logic              timeout_err
);

    localparam int IDX_W  = $clog2(NREQ);
    localparam int WDOG_W = $clog2(TMO_CYC + 1);
    localparam int GAP_W  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

    arb_state_t         r_state;
    logic [NREQ-1:0]    r_grant;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_ptr;
    logic [NREQ-1:0]    r_ack;
    logic               r_tx_start;
    logic [7:0]         r_tx_msg;
    logic               r_last;
    logic               r_tmo;
    logic [WDOG_W-1:0]  r_wdog;
    logic [GAP_W-1:0]   r_gap;

    logic [NREQ-1:0]    w_pick;
    logic [IDX_W-1:0]   w_pick_idx;
    logic [IDX_W-1:0]   w_ptr_next;

    rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick),
        .o_idx    (w_pick_idx)
    );

    assign w_ptr_next = IDX_W'(wrap_inc(int'(r_idx), NREQ));

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_ack      <= '0;
            r_tx_start <= 1'b0;
            r_tx_msg   <= 8'h00;
            r_last     <= 1'b0;
            r_tmo      <= 1'b0;
            r_wdog     <= '0;
            r_gap      <= '0;
        end else begin
            // NOTE: non-blocking defaults make the pulse outputs one cycle wide unless a state re-asserts them.
            r_tx_start <= 1'b0;
            r_ack      <= '0;
            r_tmo      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_grant <= w_pick;
                        r_idx   <= w_pick_idx;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (req[r_idx]) begin
                        r_tx_msg   <= req_data[8*r_idx +: 8];
                        r_tx_start <= 1'b1;
                        r_ack      <= r_grant;
                        r_last     <= req_last[r_idx];
                        r_wdog     <= '0;
                        r_state    <= ST_WAIT;
                    end else begin
                        r_grant <= '0;
                        r_ptr   <= w_ptr_next;
                        r_gap   <= '0;
                        r_state <= ST_GAP;
                    end
                end
                ST_WAIT: begin
                    // A done pulse overlapping our own start belongs to the previous byte.
                    if (tx_done && !r_tx_start) begin
                        if (r_last) begin
                            r_grant <= '0;
                            r_ptr   <= w_ptr_next;
                            r_gap   <= '0;
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end else if (r_wdog == WDOG_W'(TMO_CYC)) begin
                        r_tmo   <= 1'b1;
                        r_grant <= '0;
                        r_ptr   <= w_ptr_next;
                        r_gap   <= '0;
                        r_state <= ST_GAP;
                    end else begin
                        r_wdog <= r_wdog + WDOG_W'(1);
                    end
                end
                ST_GAP: begin
                    if (int'(r_gap) + 1 >= GAP_CYC) r_state <= ST_IDLE;
                    else                            r_gap   <= r_gap + GAP_W'(1);
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant       = r_grant;
    assign req_ack     = r_ack;
    assign tx_start    = r_tx_start;
    assign tx_msg      = r_tx_msg;
    assign busy        = (r_state != ST_IDLE);
    assign timeout_err = r_tmo;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester and uart_tx models, a start/ack
// monitor, and hand-computed expected byte order, grants and timing.
module tb_uart_tx_arbiter;
    import slm_pkg::*;

    localparam int NREQ     = 3;
    localparam int GAP_CYC  = 2;
    localparam int TMO_CYC  = 4095;
    localparam int DONE_DLY = 10;

    logic              clk_3125 = 1'b0;
    logic              rst_n    = 1'b0;
    logic [NREQ-1:0]   req      = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   grant;
    logic              tx_start;
    logic [7:0]        tx_msg;
    logic              tx_done  = 1'b0;
    logic              busy;
    logic              timeout_err;

    always #5 clk_3125 = ~clk_3125;

    uart_tx_arbiter #(.NREQ(NREQ), .GAP_CYC(GAP_CYC), .TMO_CYC(TMO_CYC)) dut (
        .clk_3125    (clk_3125),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .grant       (grant),
        .tx_start    (tx_start),
        .tx_msg      (tx_msg),
        .tx_done     (tx_done),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Requester model configuration (written by the main sequence only).
    logic [7:0] msg_mem [NREQ][16];
    int msg_len  [NREQ] = '{default: 1};
    int cfg_msgs [NREQ] = '{default: 0};
    int cfg_go   [NREQ] = '{default: 0};
    int blip_cyc [NREQ] = '{default: -1};
    // Requester model state.
    int go_seen  [NREQ] = '{default: 0};
    int rem      [NREQ] = '{default: 0};
    int pos      [NREQ] = '{default: 0};
    int first_req_cyc [NREQ] = '{default: 0};
    int cyc = 0;

    initial forever begin
        @(negedge clk_3125);
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                rem[i]     = 0;
                pos[i]     = 0;
                go_seen[i] = cfg_go[i];
            end
            req      = '0;
            req_last = '0;
            req_data = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ack[i] && rem[i] > 0) begin
                    if (pos[i] == msg_len[i] - 1) begin
                        pos[i] = 0;
                        rem[i]--;
                    end else begin
                        pos[i]++;
                    end
                end
                if (cfg_go[i] != go_seen[i]) begin
                    go_seen[i]       = cfg_go[i];
                    rem[i]           = cfg_msgs[i];
                    pos[i]           = 0;
                    first_req_cyc[i] = cyc;
                end
                req[i]            = (rem[i] > 0) || (cyc == blip_cyc[i]);
                req_data[8*i +: 8] = (rem[i] > 0) ? msg_mem[i][pos[i]] : 8'hA5;
                req_last[i]       = (rem[i] > 0) && (pos[i] == msg_len[i] - 1);
            end
        end
    end

    // uart_tx model: done DONE_DLY cycles after start, optionally dropping starts.
    int cfg_drop   = 0;
    bit cfg_coinc  = 1'b0;
    int drops_done = 0;
    int tx_cnt     = 0;
    bit tx_busy    = 1'b0;

    initial forever begin
        @(negedge clk_3125);
        if (!rst_n) begin
            tx_done = 1'b0;
            tx_busy = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (tx_busy) begin
                tx_cnt--;
                if (tx_cnt == 0) begin
                    tx_done = 1'b1;
                    tx_busy = 1'b0;
                end
            end
            if (tx_start) begin
                if (drops_done < cfg_drop) begin
                    drops_done++;
                end else begin
                    tx_busy = 1'b1;
                    tx_cnt  = DONE_DLY;
                    if (cfg_coinc) tx_done = 1'b1;
                end
            end
        end
    end

    // Monitor.
    int log_idx[$];
    int log_byte[$];
    int log_cyc[$];
    int ack_cnt [NREQ] = '{default: 0};
    int tmo_cnt = 0;
    int tmo_at  = 0;
    int gap_cnt = 0;
    int mcyc    = 0;

    function automatic int oh2idx(input logic [NREQ-1:0] g);
        int r = 9;
        int n = 0;
        for (int i = 0; i < NREQ; i++) if (g[i]) begin r = i; n++; end
        return (n == 1) ? r : 9;
    endfunction

    initial forever begin
        @(negedge clk_3125);
        mcyc++;
        if (rst_n) begin
            if (tx_start) begin
                log_idx.push_back(oh2idx(grant));
                log_byte.push_back(int'(tx_msg));
                log_cyc.push_back(mcyc);
            end
            for (int i = 0; i < NREQ; i++) ack_cnt[i] += int'(req_ack[i]);
            if (timeout_err) begin
                tmo_cnt++;
                tmo_at = mcyc;
            end
            if (busy && grant == '0) gap_cnt++;
        end
    end

    int base_log, base_tmo, base_gap;
    int base_ack [NREQ];

    task automatic snap();
        base_log = log_idx.size();
        base_tmo = tmo_cnt;
        base_gap = gap_cnt;
        for (int i = 0; i < NREQ; i++) base_ack[i] = ack_cnt[i];
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_3125);
        #1;
    endtask

    task automatic go(input int i, input string s, input int n);
        for (int k = 0; k < s.len(); k++) msg_mem[i][k] = s[k];
        msg_len[i]  = s.len();
        cfg_msgs[i] = n;
        cfg_go[i]   = cfg_go[i] + 1;
    endtask

    function automatic bit all_idle_req();
        for (int i = 0; i < NREQ; i++) if (rem[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        tick(3);
        while (!(all_idle_req() && !busy) && n < bound) begin
            tick(1);
            n++;
        end
        check({tag, "_done_in_time"}, 64'(n < bound), 64'd1);
    endtask

    function automatic int cyc_at(input int k);
        return (base_log + k < log_cyc.size()) ? log_cyc[base_log + k] : -1;
    endfunction

    function automatic int byte_at(input int k);
        return (base_log + k < log_byte.size()) ? log_byte[base_log + k] : -1;
    endfunction

    task automatic expect_seq(input string tag, input string idxs, input string bytes);
        check({tag, "_starts"}, 64'(log_idx.size() - base_log), 64'(idxs.len()));
        for (int k = 0; k < idxs.len(); k++) begin
            if (base_log + k < log_idx.size()) begin
                check($sformatf("%s_grant%0d", tag, k), 64'(log_idx[base_log + k]), 64'(idxs[k] - 8'h30));
                check($sformatf("%s_byte%0d", tag, k), 64'(log_byte[base_log + k]), 64'(bytes[k]));
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_grant"},   64'(grant),       64'd0);
        check({tag, "_req_ack"}, 64'(req_ack),     64'd0);
        check({tag, "_tx_start"},64'(tx_start),    64'd0);
        check({tag, "_tx_msg"},  64'(tx_msg),      64'd0);
        check({tag, "_busy"},    64'(busy),        64'd0);
        check({tag, "_tmo"},     64'(timeout_err), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        tick(2);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        tick(2);

        // Two requesters at ptr=0: whole message from 0, then from 2.
        snap();
        go(0, "SLM", 1);
        go(2, " #", 1);
        wait_done("t2", 300);
        expect_seq("t2", "00022", "SLM #");
        check("t2_space", 64'(byte_at(3)), 64'(ASCII_SPACE));
        check("t2_gap_cycles", 64'(gap_cnt - base_gap), 64'd4);

        // Three requesters holding for two messages each.
        snap();
        go(0, "S#", 2);
        go(1, "L#", 2);
        go(2, "M#", 2);
        wait_done("t3", 1000);
        expect_seq("t3", "001122001122", "S#L#M#S#L#M#");

        // Single requester, full status message.
        snap();
        go(1, "SLM-FSU1-IM-#", 1);
        wait_done("t1", 1000);
        expect_seq("t1", "1111111111111", "SLM-FSU1-IM-#");
        check("t1_first_S", 64'(byte_at(0)), 64'(ASCII_S));
        check("t1_L",       64'(byte_at(1)), 64'(ASCII_L));
        check("t1_M",       64'(byte_at(2)), 64'(ASCII_M));
        check("t1_dash",    64'(byte_at(3)), 64'(ASCII_DASH));
        check("t1_last_hash", 64'(byte_at(12)), 64'(ASCII_HASH));
        check("t1_acks", 64'(ack_cnt[1] - base_ack[1]), 64'd13);
        check("t1_gap_cycles", 64'(gap_cnt - base_gap), 64'd2);
        check("t1_req_to_start", 64'(cyc_at(0) - first_req_cyc[1]), 64'd2);
        check("t1_start_spacing", 64'(cyc_at(1) - cyc_at(0)), 64'(DONE_DLY + 2));
        check("t1_idle_busy", 64'(busy), 64'd0);

        // Watchdog: first byte never completes, next requester is served.
        snap();
        cfg_drop = 1;
        go(0, "LM", 1);
        go(1, "S#", 1);
        wait_done("t4", 6000);
        expect_seq("t4", "0110", "LS#M");
        check("t4_tmo_pulses", 64'(tmo_cnt - base_tmo), 64'd1);
        check("t4_tmo_latency", 64'(tmo_at - cyc_at(0)), 64'(TMO_CYC + 1));
        check("t4_gap_cycles", 64'(gap_cnt - base_gap), 64'd6);
        check("t4_acks0", 64'(ack_cnt[0] - base_ack[0]), 64'd2);

        // Reset in the middle of a 5-byte message.
        snap();
        go(0, "SLM-#", 1);
        n = 0;
        while (log_idx.size() < base_log + 2 && n < 300) begin
            tick(1);
            n++;
        end
        check("t5_second_byte_seen", 64'(n < 300), 64'd1);
        tick(4);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("t5_rst");
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("t5_busy_after", 64'(busy), 64'd0);
        snap();
        go(1, "S", 1);
        go(2, "L", 1);
        wait_done("t5", 300);
        expect_seq("t5", "12", "SL");

        // tx_done coincident with tx_start is ignored.
        snap();
        cfg_coinc = 1'b1;
        go(2, "L#", 1);
        wait_done("t6", 300);
        cfg_coinc = 1'b0;
        expect_seq("t6", "22", "L#");
        check("t6_start_spacing", 64'(cyc_at(1) - cyc_at(0)), 64'(DONE_DLY + 2));

        // Requester 1 withdraws in LOAD: no start, GAP, pointer advances past it.
        snap();
        blip_cyc[1] = cyc + 1;
        wait_done("t7", 100);
        check("t7_no_start", 64'(log_idx.size() - base_log), 64'd0);
        check("t7_gap_cycles", 64'(gap_cnt - base_gap), 64'd2);
        snap();
        go(0, "S", 1);
        go(2, "M", 1);
        wait_done("t7b", 300);
        expect_seq("t7b", "20", "MS");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
